out_word_packer: RTL and testbench
==================================

# out_word_packer

Downstream companion to the ReWire bit-serial datapath. Consumes the 1-bit-per-cycle result stream (`__out0`, qualified by the datapath's continue strobe) and packs it MSB-first into WIDTH-bit words. Buffers the words in a small FIFO and presents them on a valid/ready interface to the host-side consumer. Overflow is reported through a sticky flag and never stalls the datapath, which has no backpressure input.

## Interface
- WIDTH, 8, bits per packed word; must be ≥2.
- DEPTH, 4, FIFO depth in words; must be a power of two and ≥2.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_bit  in  1  serial data bit from the datapath.
- in_valid  in  1  in_bit is meaningful this cycle.
- flush  in  1  pulse; closes the current partial word.
- clear_ovf  in  1  pulse; clears overflow.
- out_data  out  WIDTH  head-of-FIFO word.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts the head word.
- level  out  $clog2(DEPTH)+1  number of words currently held.
- overflow  out  1  sticky flag; at least one word was dropped.

## Operation
- Packer state:
  - shift register sh[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1.
- When in_valid=1, in_bit is shifted in: sh <= {sh[WIDTH-2:0], in_bit}. The first bit received ends up in out_data[WIDTH-1] (MSB-first).
- Word completion: in_valid=1 with cnt=WIDTH-1.
  - Push request with word {sh[WIDTH-2:0], in_bit}.
  - cnt <= 0.
- Flush: flush=1 while the effective bit count is >0.
  - The effective count includes a same-cycle in_valid bit, which is taken before the flush.
  - The partial word is left-aligned and zero-padded in the LSBs, then pushed.
  - cnt <= 0.
- Flush with an effective count of 0 is a no-op. Flush together with a completing bit produces exactly one push, not two.
- FIFO:
  - push when a push request is present and (level<DEPTH or pop this cycle).
  - pop = out_valid & out_ready.
  - Simultaneous push and pop at full is allowed; level is unchanged.
  - Simultaneous push and pop at empty is allowed; the new word appears the next cycle.
- Drop: a push request with level=DEPTH and no pop discards the word and sets overflow. The packer still resets cnt, so alignment is preserved.
- overflow clears only on clear_ovf or rst. If a drop and clear_ovf occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. level is a separate counter, not pointer-derived.
- Once out_valid is asserted, out_data is stable until the pop (AXI-style rules).

## Timing
- Reset values:
  - out_valid=0, out_data=0, level=0, overflow=0.
  - cnt=0, sh=0, FIFO pointers=0.
- rst mid-word discards the partial bits. rst with a non-empty FIFO discards all words. No push occurs in the reset cycle.
- Latency: the bit completing a word at cycle N gives out_valid=1 and the word on out_data at cycle N+1.
- Flush at cycle N gives the padded word valid at N+1.
- Throughput: one bit per cycle in, one word per cycle out. The FIFO never fills with out_ready held high.
- out_data is driven from registered FIFO storage indexed by the registered read pointer, with no combinational path from in_bit. out_valid and level are registered.
- out_ready may combinationally depend on out_valid. out_valid does not depend on out_ready.

## Structure
- Shared package owp_pkg holds:
  - the localparam helpers: LVL_W = $clog2(DEPTH)+1, CNT_W = $clog2(WIDTH);
  - the push-request struct {logic req; logic [WIDTH-1:0] word} (parameterised via the module).
- Sub-module word_fifo (params WIDTH, DEPTH):
  - ports: clk, rst, push, push_data, pop, head, valid, level, full;
  - owns the storage, pointers and level counter.
- The top level contains only the packer, the drop/overflow logic and the instance.

## Test plan
- Single word: 8 bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 → out_data=8'hB2 one cycle after the 8th bit; out_valid high for exactly one cycle; level returns to 0.
- Gapped input: same bits with in_valid toggling every other cycle → identical word 8'hB2; no word emitted early.
- Flush: 3 bits 1,1,1, then flush → out_data=8'hE0. A flush on the next cycle (cnt=0) produces nothing. Flush in the cycle with the 8th bit of 8'hFF → a single 8'hFF.
- Overflow: out_ready=0, stream 5 words 8'h01..8'h05 (DEPTH=4) → level=4, overflow=1, and 8'h05 is dropped. Then out_ready=1 → pops 01,02,03,04 in order. clear_ovf → overflow=0.
- Full with simultaneous pop: level=4 and out_ready=1 in the same cycle as a 5th word completes → word accepted, level stays 4, overflow stays 0.
- Reset mid-operation: 5 bits in with 2 words queued, assert rst for 1 cycle → all outputs 0. The next 8 bits 8'h3C yield 8'h3C with no stale bits.

Source files
------------

// File: rtl/owp_pkg.sv
// owp_pkg: shared width helpers for the output word packer.
package owp_pkg;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/out_word_packer_if.sv
// out_word_packer_if: serial bit stream in, packed word valid/ready out.
interface out_word_packer_if import owp_pkg::*; #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  logic in_bit, in_valid, flush, clear_ovf, out_ready, out_valid, overflow;
  logic [WIDTH-1:0] out_data;
  logic [lvl_w(DEPTH)-1:0] level;
  modport master(output in_bit, in_valid, flush, clear_ovf, out_ready,
                 input out_data, out_valid, level, overflow);
  modport slave(input in_bit, in_valid, flush, clear_ovf, out_ready,
                output out_data, out_valid, level, overflow);
endinterface

// File: rtl/out_word_packer_word_fifo.sv
// word_fifo: registered word FIFO with an independent level counter.
module word_fifo import owp_pkg::*; #(parameter int WIDTH = 8, parameter int DEPTH = 4) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      valid,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] nxt;
  assign head = mem[rp];
  assign full = level == (AW+1)'(DEPTH);
  assign nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      level <= nxt;
      valid <= nxt != '0;
    end
endmodule

// File: rtl/out_word_packer.sv
// out_word_packer: packs a bit-serial stream MSB-first into words and queues them.
module out_word_packer import owp_pkg::*; #(parameter int WIDTH = 8, parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  out_word_packer_if.slave b
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam int LVL_W = lvl_w(DEPTH);
  localparam logic [CNT_W:0] WL = (CNT_W+1)'(WIDTH);
  typedef struct packed {
    logic req;
    logic [WIDTH-1:0] word;
  } push_req_t;
  push_req_t pr;
  logic [WIDTH-1:0] sh, nsh, head;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] n;
  logic [LVL_W-1:0] level;
  logic pop, full, valid, ovf;
  assign nsh = b.in_valid ? {sh[WIDTH-2:0], b.in_bit} : sh;
  assign n = {1'b0, cnt} + (CNT_W+1)'(b.in_valid);
  assign pr.req = n == WL || (b.flush && n != '0);
  // shifting by the missing bit count left-aligns a partial word and zero-pads it
  assign pr.word = nsh << (WL - n);
  assign pop = valid & b.out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      sh <= nsh;
      cnt <= pr.req ? '0 : n[CNT_W-1:0];
      ovf <= (pr.req && full && !pop) || (ovf && !b.clear_ovf);
    end
  word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(pr.req && (!full || pop)),
    .push_data(pr.word),
    .pop(pop),
    .head(head),
    .valid(valid),
    .level(level),
    .full(full)
  );
  assign b.out_data = head;
  assign b.out_valid = valid;
  assign b.level = level;
  assign b.overflow = ovf;
endmodule

// File: tb/tb_out_word_packer.sv
// tb_out_word_packer: directed table, corner sequences and random run against a queue model.
module tb_out_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  out_word_packer_if #(.WIDTH(8), .DEPTH(4)) bus();
  out_word_packer #(.WIDTH(8), .DEPTH(4)) dut(.clk(clk), .rst(rst), .b(bus.slave));
  typedef struct {
    bit r, v, b, f, rdy;
    bit ev;
    logic [7:0] ed;
    int el;
    bit eo;
  } vec_t;
  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned q[$];
  int nb = 0;
  int acc = 0;
  bit ovf = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic want(input string nm, input bit v, input logic [7:0] d, input int l, input bit o, input bit cd);
    chk({nm, "_valid"}, bus.out_valid, v);
    chk({nm, "_level"}, bus.level, l);
    chk({nm, "_ovf"}, bus.overflow, o);
    if (cd) chk({nm, "_data"}, bus.out_data, d);
  endtask
  // word-level reference: bits accumulate as an integer, words live in a 4-deep queue
  task automatic cyc(input bit r, input bit v, input bit bi, input bit f, input bit c, input bit rdy);
    bit pop, have, drop;
    rst = r;
    bus.in_valid = v;
    bus.in_bit = bi;
    bus.flush = f;
    bus.clear_ovf = c;
    bus.out_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      nb = 0;
      acc = 0;
      ovf = 0;
    end else begin
      pop = q.size() > 0 && rdy;
      if (v) begin
        acc = acc * 2 + int'(bi);
        nb++;
      end
      have = nb == 8 || (f && nb > 0);
      if (pop) void'(q.pop_front());
      drop = have && q.size() == 4;
      if (have) begin
        if (!drop) q.push_back(8'(acc << (8 - nb)));
        nb = 0;
        acc = 0;
      end
      if (drop) ovf = 1;
      else if (c) ovf = 0;
    end
    #1;
    chk("model_valid", bus.out_valid, q.size() != 0);
    chk("model_level", bus.level, q.size());
    chk("model_ovf", bus.overflow, ovf);
    if (q.size() != 0) chk("model_data", bus.out_data, q[0]);
  endtask
  task automatic send_byte(input logic [7:0] val, input bit rdy, input bit rdy_last);
    for (int i = 7; i >= 0; i--) cyc(0, 1, val[i], 0, 0, i == 0 ? rdy_last : rdy);
  endtask
  function automatic void addv(input bit r, input bit v, input bit b, input bit f, input bit rdy,
                               input bit ev, input logic [7:0] ed, input int el);
    tv.push_back('{r, v, b, f, rdy, ev, ed, el, 1'b0});
  endfunction
  initial begin
    logic [7:0] pat;
    bus.in_bit = 0;
    bus.in_valid = 0;
    bus.flush = 0;
    bus.clear_ovf = 0;
    bus.out_ready = 0;
    pat = 8'hB2;
    addv(1, 0, 0, 0, 1, 0, 8'h00, 0);
    for (int i = 7; i >= 1; i--) addv(0, 1, pat[i], 0, 1, 0, 8'h00, 0);
    addv(0, 1, pat[0], 0, 1, 1, 8'hB2, 1);
    addv(0, 0, 0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) addv(0, 1, 1, 0, 1, 0, 8'h00, 0);
    addv(0, 0, 0, 1, 1, 1, 8'hE0, 1);
    addv(0, 0, 0, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) addv(0, 1, 1, 0, 1, 0, 8'h00, 0);
    addv(0, 1, 1, 1, 1, 1, 8'hFF, 1);
    addv(0, 0, 0, 0, 1, 0, 8'h00, 0);
    foreach (tv[i]) begin
      cyc(tv[i].r, tv[i].v, tv[i].b, tv[i].f, 0, tv[i].rdy);
      want("tbl", tv[i].ev, tv[i].ed, tv[i].el, tv[i].eo, tv[i].ev || tv[i].r);
    end
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 1, pat[i], 0, 0, 1);
      if (i != 0) begin
        chk("gap_early", bus.out_valid, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
      end
    end
    want("gap", 1, 8'hB2, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 0, 0);
    want("ovf_full", 1, 8'h01, 4, 1, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      want("ovf_drain", k < 4, 8'(k + 1), 4 - k, 1, k < 4);
    end
    cyc(0, 0, 0, 0, 1, 0);
    want("ovf_clear", 0, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 4; k++) send_byte(8'(k * 17), 0, 0);
    send_byte(8'h55, 0, 1);
    want("full_pop", 1, 8'h22, 4, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 1);
    chk("full_pop_drained", bus.out_valid, 1'b0);
    send_byte(8'hA1, 0, 0);
    send_byte(8'hA2, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    want("rst_mid", 0, 8'h00, 0, 0, 1);
    send_byte(8'h3C, 0, 0);
    want("rst_after", 1, 8'h3C, 1, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(199) == 0, $urandom_range(9) < 7, 1'($urandom), $urandom_range(19) == 0,
          $urandom_range(29) == 0, 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
